// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, instruction
// field positions, FSM encoding and the signed-overflow helper.
package dp_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB = 12;
  localparam int RA_LSB = 9;
  localparam int RB_LSB = 6;
  localparam int IMM_W  = 9;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Signed add overflow from operand/result sign bits; pass ~sb for subtraction.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/multicycle_data_path_if.sv
// Instruction-fetch and data-memory req/ack buses between the core (master)
// and the memories (slave).
interface multicycle_data_path_if #(
  parameter int PC_W    = 8,
  parameter int DADDR_W = 9,
  parameter int DATA_W  = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dp_reg_file.sv
// Eight-entry register file: two asynchronous read ports, one synchronous
// write port, entry 0 hard-wired to zero.
module dp_reg_file
  import dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_r [8];

  assign ra_data = (ra_addr == 3'd0) ? {DATA_W{1'b0}} : regs_r[ra_addr];
  assign rb_data = (rb_addr == 3'd0) ? {DATA_W{1'b0}} : regs_r[rb_addr];

  // Register storage; writes aimed at R0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (wa != 3'd0)) begin
      regs_r[wa] <= wd;
    end
  end

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath; both memories sit behind
// req/ack handshakes so slow RAMs simply stretch FETCH or MEM.
module multicycle_data_path
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 8,
  parameter int DADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_data_path_if.master bus,
  output logic [3:0]            opcode,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  retire,
  output logic                  ovf,
  output logic                  halted
);

  localparam int MSB = DATA_W - 1;

  state_t              state_r;
  logic [PC_W-1:0]     pc_r;
  logic [15:0]         ir_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   alu_r;
  logic [DATA_W-1:0]   load_r;
  logic                retire_r;
  logic                ovf_r;
  logic                halted_r;
  logic                imem_req_r;
  logic                dmem_req_r;
  logic                dmem_we_r;
  logic [DADDR_W-1:0]  dmem_addr_r;
  logic [DATA_W-1:0]   dmem_wdata_r;

  logic [3:0]          op_s;
  logic [DATA_W-1:0]   rd_a_s;
  logic [DATA_W-1:0]   rd_b_s;
  logic [DATA_W-1:0]   imm_s;
  logic [DATA_W-1:0]   sum_s;
  logic [DATA_W-1:0]   diff_s;
  logic [DATA_W-1:0]   addi_s;
  logic                rf_we_s;
  logic [DATA_W-1:0]   rf_wd_s;

  assign op_s   = ir_r[OP_LSB +: 4];
  assign imm_s  = DATA_W'(ir_r[IMM_W-1:0]);
  assign sum_s  = a_r + b_r;
  assign diff_s = a_r - b_r;
  assign addi_s = a_r + imm_s;

  assign bus.imem_req   = imem_req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_wdata = dmem_wdata_r;
  assign opcode         = op_s;
  assign alu_result     = alu_r;
  assign retire         = retire_r;
  assign ovf            = ovf_r;
  assign halted         = halted_r;

  dp_reg_file #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (ir_r[RA_LSB +: REG_AW]),
    .rb_addr (ir_r[RB_LSB +: REG_AW]),
    .ra_data (rd_a_s),
    .rb_data (rd_b_s),
    .we      (rf_we_s),
    .wa      (ir_r[RA_LSB +: REG_AW]),
    .wd      (rf_wd_s)
  );

  // Writeback port: arithmetic results or the latched load word.
  always_comb begin
    rf_we_s = 1'b0;
    rf_wd_s = alu_r;
    if (state_r == ST_WB) begin
      case (op_s)
        OP_ADD, OP_ADDI, OP_SUB: rf_we_s = 1'b1;
        OP_LW: begin
          rf_we_s = 1'b1;
          rf_wd_s = load_r;
        end
        default: rf_we_s = 1'b0;
      endcase
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Control FSM; every externally visible signal is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_FETCH;
      pc_r         <= {PC_W{1'b0}};
      ir_r         <= 16'h0000;
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      alu_r        <= {DATA_W{1'b0}};
      load_r       <= {DATA_W{1'b0}};
      retire_r     <= 1'b0;
      ovf_r        <= 1'b0;
      halted_r     <= 1'b0;
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {DADDR_W{1'b0}};
      dmem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      retire_r <= 1'b0;
      case (state_r)
        ST_FETCH: begin
          if (imem_req_r && bus.imem_ack) begin
            ir_r       <= bus.imem_rdata;
            imem_req_r <= 1'b0;
            state_r    <= ST_DECODE;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          a_r     <= rd_a_s;
          b_r     <= rd_b_s;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op_s)
            OP_ADD: begin
              alu_r   <= sum_s;
              ovf_r   <= ovf_r | add_ovf(a_r[MSB], b_r[MSB], sum_s[MSB]);
              state_r <= ST_WB;
            end
            OP_SUB: begin
              alu_r   <= diff_s;
              ovf_r   <= ovf_r | add_ovf(a_r[MSB], ~b_r[MSB], diff_s[MSB]);
              state_r <= ST_WB;
            end
            OP_ADDI: begin
              alu_r   <= addi_s;
              ovf_r   <= ovf_r | add_ovf(a_r[MSB], imm_s[MSB], addi_s[MSB]);
              state_r <= ST_WB;
            end
            OP_LW: begin
              dmem_req_r  <= 1'b1;
              dmem_we_r   <= 1'b0;
              dmem_addr_r <= ir_r[DADDR_W-1:0];
              state_r     <= ST_MEM;
            end
            OP_SW: begin
              dmem_req_r   <= 1'b1;
              dmem_we_r    <= 1'b1;
              dmem_addr_r  <= ir_r[DADDR_W-1:0];
              dmem_wdata_r <= a_r;
              state_r      <= ST_MEM;
            end
            OP_HALT: begin
              halted_r <= 1'b1;
              state_r  <= ST_HALT;
            end
            default: state_r <= ST_WB;
          endcase
        end
        ST_MEM: begin
          // A store completes here; only loads continue to writeback.
          if (dmem_req_r && bus.dmem_ack) begin
            dmem_req_r <= 1'b0;
            if (dmem_we_r) begin
              retire_r   <= 1'b1;
              pc_r       <= pc_r + PC_W'(1);
              imem_req_r <= 1'b1;
              state_r    <= ST_FETCH;
            end else begin
              load_r  <= bus.dmem_rdata;
              state_r <= ST_WB;
            end
          end
        end
        ST_WB: begin
          retire_r   <= 1'b1;
          pc_r       <= pc_r + PC_W'(1);
          imem_req_r <= 1'b1;
          state_r    <= ST_FETCH;
        end
        ST_HALT: state_r <= ST_HALT;
        default: begin
          imem_req_r <= 1'b0;
          state_r    <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_data_path.sv
// Scoreboard bench: programs push expected fetches, data accesses and
// retirements; a negedge monitor pops and compares as the core produces them.
module tb_multicycle_data_path;
  import dp_pkg::*;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          len;
  } st_t;

  typedef struct {
    logic [15:0] alu;
    logic        ovf;
  } rt_t;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        retire;
  logic        ovf;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;
  int dmem_delay = 0;
  bit retire_chk_en = 1'b1;
  bit gap_chk_en = 1'b0;
  int cyc = 0;
  int last_ret = -1;

  logic [15:0] rom [256];
  logic [15:0] dram [512];
  logic [7:0]  fq [$];
  st_t         sq [$];
  rt_t         rq [$];

  multicycle_data_path_if #(.PC_W(8), .DADDR_W(9), .DATA_W(16)) bus ();

  multicycle_data_path #(.DATA_W(16), .PC_W(8), .DADDR_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .opcode     (opcode),
    .alu_result (alu_result),
    .retire     (retire),
    .ovf        (ovf),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b, 6'b000000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] a, input logic [8:0] imm);
    return {op, a, imm};
  endfunction

  task automatic push_st(input logic we, input logic [8:0] addr, input logic [15:0] wd, input int len);
    st_t e;
    e.we = we; e.addr = addr; e.wdata = wd; e.len = len;
    sq.push_back(e);
  endtask

  task automatic push_rt(input logic [15:0] alu, input logic o);
    rt_t e;
    e.alu = alu; e.ovf = o;
    rq.push_back(e);
  endtask

  task automatic push_fetch(input int first, input int last);
    for (int i = first; i <= last; i++) fq.push_back(8'(i));
  endtask

  // Instruction ROM (single-cycle) and data RAM with programmable ack delay.
  initial begin
    int dcnt;
    dcnt = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req;
      bus.imem_rdata = rom[bus.imem_addr];
      if (bus.dmem_req) begin
        if (dcnt == dmem_delay) begin
          bus.dmem_ack = 1'b1;
          bus.dmem_rdata = dram[bus.dmem_addr];
          if (bus.dmem_we) dram[bus.dmem_addr] = bus.dmem_wdata;
        end else begin
          bus.dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  // Monitor: compares every fetch, data access and retirement with the queues.
  initial begin
    logic prev_ireq, prev_dreq, unstable;
    logic [25:0] cap;
    int dlen, cur_len;
    st_t s;
    rt_t r;
    prev_ireq = 1'b0; prev_dreq = 1'b0; unstable = 1'b0;
    cap = '0; dlen = 0; cur_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.imem_req && !prev_ireq) begin
        if (fq.size() == 0) fail_unexpected("unexpected_fetch", 32'(bus.imem_addr));
        else check("fetch_addr", 32'(bus.imem_addr), 32'(fq.pop_front()));
      end
      if (bus.dmem_req && !prev_dreq) begin
        if (sq.size() == 0) begin
          fail_unexpected("unexpected_dmem", 32'(bus.dmem_addr));
          cur_len = 0;
        end else begin
          s = sq.pop_front();
          check("dmem_we", 32'(bus.dmem_we), 32'(s.we));
          check("dmem_addr", 32'(bus.dmem_addr), 32'(s.addr));
          if (s.we) check("dmem_wdata", 32'(bus.dmem_wdata), 32'(s.wdata));
          cur_len = s.len;
        end
        cap = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
        dlen = 1;
        unstable = 1'b0;
      end else if (bus.dmem_req) begin
        dlen++;
        if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} != cap) unstable = 1'b1;
      end else if (prev_dreq && cur_len != 0) begin
        check("dmem_req_cycles", 32'(dlen), 32'(cur_len));
        check("dmem_stable", 32'(unstable), 32'd0);
      end
      if (retire && retire_chk_en) begin
        if (rq.size() == 0) fail_unexpected("unexpected_retire", 32'(alu_result));
        else begin
          r = rq.pop_front();
          check("retire_alu", 32'(alu_result), 32'(r.alu));
          check("retire_ovf", 32'(ovf), 32'(r.ovf));
        end
        if (gap_chk_en && last_ret >= 0) check("retire_gap", 32'(cyc - last_ret), 32'd4);
        last_ret = cyc;
      end
      prev_ireq = bus.imem_req;
      prev_dreq = bus.dmem_req;
    end
  end

  task automatic check_reset_outputs();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check("rst_dmem_addr", 32'(bus.dmem_addr), 32'd0);
    check("rst_dmem_wdata", 32'(bus.dmem_wdata), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_alu_result", 32'(alu_result), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
  endtask

  task automatic start_phase();
    rst = 1'b1;
    @(negedge clk);
    fq.delete(); sq.delete(); rq.delete();
    for (int i = 0; i < 256; i++) rom[i] = {OP_HALT, 12'h000};
    for (int i = 0; i < 512; i++) dram[i] = 16'h0000;
    dmem_delay = 0;
    retire_chk_en = 1'b1;
    gap_chk_en = 1'b0;
    last_ret = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("imem_req_first_edge", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic run_until_halt(input int max_cyc);
    int c;
    c = 0;
    while (!halted && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_fetch_left"}, 32'(fq.size()), 32'd0);
    check({name, "_dmem_left"}, 32'(sq.size()), 32'd0);
    check({name, "_retire_left"}, 32'(rq.size()), 32'd0);
  endtask

  initial begin
    int busy, c;
    rst = 1'b1;

    // Basic ALU sequence, retire cadence, HALT at PC 3.
    start_phase();
    check_reset_outputs();
    rom[0] = enc_i(OP_ADDI, 3'd1, 9'd5);
    rom[1] = enc_i(OP_ADDI, 3'd2, 9'd3);
    rom[2] = enc_r(OP_ADD, 3'd1, 3'd2);
    push_fetch(0, 3);
    push_rt(16'd5, 1'b0); push_rt(16'd3, 1'b0); push_rt(16'd8, 1'b0);
    gap_chk_en = 1'b1;
    release_reset();
    run_until_halt(100);
    check("halt_opcode", 32'(opcode), 32'(OP_HALT));
    check("halt_pc", 32'(bus.imem_addr), 32'd3);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req || !halted) busy++;
    end
    check("halt_quiet_cycles", 32'(busy), 32'd0);
    check_drained("p1");

    // R0 stays zero; SUB wraps to 0xFFFF.
    start_phase();
    rom[0] = enc_i(OP_ADDI, 3'd0, 9'd7);
    rom[1] = enc_r(OP_ADD, 3'd3, 3'd0);
    rom[2] = enc_i(OP_ADDI, 3'd1, 9'd1);
    rom[3] = enc_r(OP_SUB, 3'd3, 3'd1);
    rom[4] = enc_i(OP_SW, 3'd3, 9'h002);
    rom[5] = enc_i(OP_SW, 3'd0, 9'h003);
    push_fetch(0, 6);
    push_rt(16'h0007, 1'b0); push_rt(16'h0000, 1'b0); push_rt(16'h0001, 1'b0);
    push_rt(16'hFFFF, 1'b0); push_rt(16'hFFFF, 1'b0); push_rt(16'hFFFF, 1'b0);
    push_st(1'b1, 9'h002, 16'hFFFF, 1);
    push_st(1'b1, 9'h003, 16'h0000, 1);
    release_reset();
    run_until_halt(200);
    check_drained("p2");

    // Slow data RAM: three wait cycles on every access, store then reload.
    start_phase();
    dmem_delay = 3;
    rom[0] = enc_i(OP_ADDI, 3'd1, 9'h0AB);
    rom[1] = enc_i(OP_SW, 3'd1, 9'h1A5);
    rom[2] = enc_i(OP_LW, 3'd4, 9'h1A5);
    rom[3] = enc_i(OP_SW, 3'd4, 9'h010);
    push_fetch(0, 4);
    push_rt(16'h00AB, 1'b0); push_rt(16'h00AB, 1'b0);
    push_rt(16'h00AB, 1'b0); push_rt(16'h00AB, 1'b0);
    push_st(1'b1, 9'h1A5, 16'h00AB, 4);
    push_st(1'b0, 9'h1A5, 16'h0000, 4);
    push_st(1'b1, 9'h010, 16'h00AB, 4);
    release_reset();
    run_until_halt(200);
    check_drained("p3");

    // Signed overflow 0x7FFF+1 sets ovf, which then stays set.
    start_phase();
    dram[9'h020] = 16'h7FFF;
    rom[0] = enc_i(OP_LW, 3'd1, 9'h020);
    rom[1] = enc_i(OP_ADDI, 3'd1, 9'd1);
    rom[2] = enc_i(OP_ADDI, 3'd2, 9'd2);
    rom[3] = enc_r(OP_ADD, 3'd2, 3'd2);
    rom[4] = enc_i(OP_SW, 3'd1, 9'h021);
    push_fetch(0, 5);
    push_rt(16'h0000, 1'b0); push_rt(16'h8000, 1'b1); push_rt(16'h0002, 1'b1);
    push_rt(16'h0004, 1'b1); push_rt(16'h0004, 1'b1);
    push_st(1'b0, 9'h020, 16'h0000, 1);
    push_st(1'b1, 9'h021, 16'h8000, 1);
    release_reset();
    run_until_halt(200);
    check("ovf_sticky_at_halt", 32'(ovf), 32'd1);
    check_drained("p4");

    // NOPs through the whole PC range: 0xFF is followed by 0x00.
    start_phase();
    for (int i = 0; i < 256; i++) rom[i] = 16'h5000;
    retire_chk_en = 1'b0;
    push_fetch(0, 255);
    push_fetch(0, 1);
    release_reset();
    c = 0;
    while (fq.size() != 0 && c < 1500) begin
      @(negedge clk);
      c++;
    end
    check("pc_wrap_fetches_left", 32'(fq.size()), 32'd0);

    // Asynchronous reset while a store is waiting for its ack.
    start_phase();
    dmem_delay = 10;
    rom[0] = enc_i(OP_SW, 3'd0, 9'h005);
    push_fetch(0, 0);
    push_st(1'b1, 9'h005, 16'h0000, 0);
    release_reset();
    c = 0;
    while (!bus.dmem_req && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("mid_mem_reached", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    dmem_delay = 0;
    push_fetch(0, 1);
    push_st(1'b1, 9'h005, 16'h0000, 1);
    push_rt(16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_until_halt(100);
    check_drained("p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
